// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared wall-clock types and unit moduli
package clock_pkg;

  // Adjust-button sequencer states
  typedef enum logic [1:0] {
    ADJ_IDLE   = 2'd0,
    ADJ_FIRST  = 2'd1,
    ADJ_HOLD   = 2'd2,
    ADJ_REPEAT = 2'd3
  } adj_state_t;

  // Moduli of the chained time units
  localparam int MS_MOD  = 1000;
  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;
  localparam int HR_MOD  = 24;

  // Number of bits needed to hold values 0..n
  function automatic int cnt_bits(input int n);
    int b;
    b = 1;
    while ((1 << b) <= n) b = b + 1;
    return b;
  endfunction

endpackage

// File: rtl/adj_repeat.sv
// rtl/adj_repeat.sv - button edge detect with hold-to-repeat step generator
module adj_repeat
  import clock_pkg::*;
#(
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic up,
  input  logic down,
  output logic step_up,
  output logic step_dn
);

  localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int HW   = cnt_bits(HMAX - 1);
  localparam logic [HW-1:0] DLY_LD = HW'(REPEAT_DLY - 1);
  localparam logic [HW-1:0] PER_LD = HW'(REPEAT_PER - 1);

  adj_state_t    state;
  logic          dir_up;
  logic [HW-1:0] hold_cnt;
  logic          prev_up;
  logic          prev_dn;

  logic rise_up;
  logic rise_dn;
  logic held;
  logic timed_out;
  logic step;

  // A press counts only when exactly one button is down and that button was up last cycle
  assign rise_up   = up & ~down & ~prev_up;
  assign rise_dn   = down & ~up & ~prev_dn;
  assign held      = dir_up ? (up & ~down) : (down & ~up);
  assign timed_out = (hold_cnt == '0);
  assign step      = (state == ADJ_FIRST) |
                     (((state == ADJ_HOLD) | (state == ADJ_REPEAT)) & held & timed_out);
  assign step_up   = step & dir_up;
  assign step_dn   = step & ~dir_up;

  // Press/hold sequencer; prev_* reset high so a button held through reset must be re-pressed
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_up  <= 1'b1;
      prev_dn  <= 1'b1;
      state    <= ADJ_IDLE;
      dir_up   <= 1'b1;
      hold_cnt <= '0;
    end else begin
      prev_up <= up;
      prev_dn <= down;
      if (rise_up | rise_dn) begin
        state  <= ADJ_FIRST;
        dir_up <= rise_up;
      end else begin
        case (state)
          ADJ_FIRST: begin
            state    <= ADJ_HOLD;
            hold_cnt <= DLY_LD;
          end
          ADJ_HOLD, ADJ_REPEAT: begin
            if (!held) begin
              state <= ADJ_IDLE;
            end else if (timed_out) begin
              state    <= ADJ_REPEAT;
              hold_cnt <= PER_LD;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: state <= ADJ_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/time_unit_counter.sv
// rtl/time_unit_counter.sv - modulo-N time unit counter with carry chain and user adjust
module time_unit_counter
  import clock_pkg::*;
#(
  parameter int MODULUS    = SEC_MOD,
  parameter int WIDTH      = 6,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100,
  parameter bit ADJ_CARRY  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             set_mode,
  input  logic             up,
  input  logic             down,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             step_up;
  logic             step_dn;
  logic             new_step;
  logic             pend_valid;
  logic             pend_up;
  logic             load_ok;
  logic             tick_run;
  logic             apply_valid;
  logic             apply_up;
  logic             step_wrap;
  logic [WIDTH-1:0] step_cnt;

  adj_repeat #(
    .REPEAT_DLY(REPEAT_DLY),
    .REPEAT_PER(REPEAT_PER)
  ) u_adj (
    .clk    (clk),
    .reset  (reset),
    .up     (up),
    .down   (down),
    .step_up(step_up),
    .step_dn(step_dn)
  );

  assign new_step = step_up | step_dn;
  assign load_ok  = ({1'b0, load_val} < MOD_EXT);
  assign tick_run = tick_in & ~set_mode;

  // Pick the step to apply (an older pending step goes first) and its wrapped result
  always_comb begin
    apply_valid = pend_valid | new_step;
    apply_up    = pend_valid ? pend_up : step_up;
    step_wrap   = 1'b0;
    step_cnt    = count;
    if (apply_up) begin
      step_wrap = (count == MAX_VAL);
      step_cnt  = step_wrap ? '0 : count + 1'b1;
    end else begin
      step_wrap = (count == '0);
      step_cnt  = step_wrap ? MAX_VAL : count - 1'b1;
    end
  end

  // Counter update in priority order reset > load > tick > adjust step
  always_ff @(posedge clk) begin
    carry_out  <= 1'b0;
    borrow_out <= 1'b0;
    load_err   <= 1'b0;
    if (reset) begin
      count      <= '0;
      pend_valid <= 1'b0;
      pend_up    <= 1'b0;
    end else if (load_en) begin
      if (load_ok) begin
        count      <= load_val;
        pend_valid <= 1'b0;
      end else begin
        load_err <= 1'b1;
        if (new_step) begin
          pend_valid <= 1'b1;
          pend_up    <= step_up;
        end
      end
    end else if (tick_run) begin
      count     <= (count == MAX_VAL) ? '0 : count + 1'b1;
      carry_out <= (count == MAX_VAL);
      if (new_step) begin
        pend_valid <= 1'b1;
        pend_up    <= step_up;
      end
    end else if (apply_valid) begin
      count      <= step_cnt;
      carry_out  <= ADJ_CARRY & apply_up & step_wrap;
      borrow_out <= ADJ_CARRY & ~apply_up & step_wrap;
      // A fresh step arriving while a pending one drains takes its place
      pend_valid <= pend_valid & new_step;
      pend_up    <= step_up;
    end
  end

endmodule
